// File: rtl/udp_sweep_pkg.sv
// rtl/udp_sweep_pkg.sv - shared types and constants for the UDP circuit sweep self-test
package udp_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_VEC = 16;
    localparam int IDX_W   = 4;
    localparam int CNT_OUT_W = 5;

    // Response maps of the golden circuit: E = minterms 0,2,4,6,7 of ABC, F = E & D
    localparam logic [NUM_VEC-1:0] UDP02467_EXP_E = 16'hF333;
    localparam logic [NUM_VEC-1:0] UDP02467_EXP_F = 16'hA222;

endpackage

// File: rtl/udp_mism_reduce.sv
// rtl/udp_mism_reduce.sv - mismatch vector to error count and lowest failing index
module udp_mism_reduce
    import udp_sweep_pkg::*;
(
    input  logic [NUM_VEC-1:0]   mism,
    output logic [CNT_OUT_W-1:0] popcnt,
    output logic [IDX_W-1:0]     low_idx
);

    // Scan from the top down so the last hit is the lowest set bit
    always_comb begin
        popcnt  = '0;
        low_idx = '0;
        for (int i = NUM_VEC - 1; i >= 0; i--) begin
            popcnt = popcnt + CNT_OUT_W'(mism[i]);
            if (mism[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/udp_sweep_ctrl.sv
// rtl/udp_sweep_ctrl.sv - exhaustive 16-vector sweep of the UDP circuit with map compare
module udp_sweep_ctrl
    import udp_sweep_pkg::*;
#(
    parameter int                 SETTLE = 2,
    parameter logic [NUM_VEC-1:0] EXP_E  = UDP02467_EXP_E,
    parameter logic [NUM_VEC-1:0] EXP_F  = UDP02467_EXP_F
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 drv_a,
    output logic                 drv_b,
    output logic                 drv_c,
    output logic                 drv_d,
    input  logic                 dut_e,
    input  logic                 dut_f,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [NUM_VEC-1:0]   e_map,
    output logic [NUM_VEC-1:0]   f_map,
    output logic [IDX_W-1:0]     fail_idx,
    output logic [CNT_OUT_W-1:0] err_cnt
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t                 state;
    state_t                 state_nxt;
    logic [IDX_W-1:0]       idx;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       drv;
    logic                   last_sample;
    logic                   last_vec;
    logic [NUM_VEC-1:0]     mism;
    logic [CNT_OUT_W-1:0]   mism_cnt;
    logic [IDX_W-1:0]       mism_idx;

    assign last_sample = (state == DRIVE) && (cnt == CNT_W'(SETTLE - 1));
    assign last_vec    = (idx == IDX_W'(NUM_VEC - 1));
    assign mism        = (e_map ^ EXP_E) | (f_map ^ EXP_F);

    assign {drv_a, drv_b, drv_c, drv_d} = drv;
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    udp_mism_reduce u_reduce (
        .mism    (mism),
        .popcnt  (mism_cnt),
        .low_idx (mism_idx)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DRIVE;
            DRIVE:   if (last_sample && last_vec) state_nxt = CHECK;
            CHECK:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            drv      <= '0;
            pass     <= 1'b0;
            e_map    <= '0;
            f_map    <= '0;
            fail_idx <= '0;
            err_cnt  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx      <= '0;
                        cnt      <= '0;
                        drv      <= '0;
                        pass     <= 1'b0;
                        e_map    <= '0;
                        f_map    <= '0;
                        fail_idx <= '0;
                        err_cnt  <= '0;
                    end
                end
                DRIVE: begin
                    if (last_sample) begin
                        e_map[idx] <= dut_e;
                        f_map[idx] <= dut_f;
                        cnt        <= '0;
                        // drv follows idx from a flop so the circuit never sees decode glitches
                        if (last_vec) begin
                            drv <= '0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                            drv <= idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                CHECK: begin
                    err_cnt  <= mism_cnt;
                    fail_idx <= mism_idx;
                    pass     <= (mism == '0);
                end
                default: ;
            endcase
        end
    end

endmodule
